// File: rtl/pe_r8_pkg.sv
// Shared types and helpers for the radix-8 Booth processing elements.
// Group count, Booth group bundle, tile states, error bits, saturating add.
package pe_r8_pkg;

  function automatic int gc_of(input int w);
    return (w + 3) / 3;
  endfunction

  typedef struct packed {
    logic s;
    logic d;
    logic t;
    logic q;
    logic n;
  } booth_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tile_st_t;

  localparam int ERR_SEQ = 0;
  localparam int ERR_OVR = 1;
  localparam int ERR_SAT = 2;

  function automatic logic add_ovf(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int                 w
  );
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    return (sum > hi) || (sum < (-hi - 64'sd1));
  endfunction

  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int                 w,
    input logic               sat
  );
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    if (sat && (sum > hi)) sum = hi;
    if (sat && (sum < lo)) sum = lo;
    return sum;
  endfunction

endpackage

// File: rtl/pe_os_r8_acc_if.sv
// Operand/control bundle carried between neighbouring PEs.
// The producer uses master, the consuming PE uses slave.
interface pe_os_r8_acc_if
  import pe_r8_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GC    = gc_of(WIDTH)
);
  logic                    VLD;
  logic                    CLR;
  logic                    LAST;
  logic [GC-1:0]           s;
  logic [GC-1:0]           d;
  logic [GC-1:0]           t;
  logic [GC-1:0]           q;
  logic [GC-1:0]           n;
  logic signed [WIDTH-1:0] Y;
  logic signed [WIDTH+1:0] TMY;

  modport master (
    output VLD, CLR, LAST,
    output s, d, t, q, n,
    output Y, TMY
  );

  modport slave (
    input VLD, CLR, LAST,
    input s, d, t, q, n,
    input Y, TMY
  );
endinterface

// File: rtl/r8_pp_sum.sv
// Radix-8 Booth partial-product select and shift-add.
// Priority q>t>d>s per group; no magnitude bit yields zero.
module r8_pp_sum
  import pe_r8_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GC    = gc_of(WIDTH)
) (
  input  logic [GC-1:0]             s,
  input  logic [GC-1:0]             d,
  input  logic [GC-1:0]             t,
  input  logic [GC-1:0]             q,
  input  logic [GC-1:0]             n,
  input  logic signed [WIDTH-1:0]   Y,
  input  logic signed [WIDTH+1:0]   TMY,
  output logic signed [2*WIDTH+1:0] P
);
  localparam int PW = 2 * WIDTH + 2;

  logic signed [PW-1:0] y1;
  logic signed [PW-1:0] y2;
  logic signed [PW-1:0] y3;
  logic signed [PW-1:0] y4;
  booth_t               grp;
  logic signed [PW-1:0] mag;

  assign y1 = {{(PW-WIDTH){Y[WIDTH-1]}}, Y};
  assign y2 = y1 <<< 1;
  assign y4 = y1 <<< 2;
  assign y3 = {{(PW-WIDTH-2){TMY[WIDTH+1]}}, TMY};

  // select each group's multiple, apply sign, weight by 8^g and sum
  always_comb begin
    P   = '0;
    grp = '0;
    mag = '0;
    for (int g = 0; g < GC; g++) begin
      grp = '{s: s[g], d: d[g], t: t[g], q: q[g], n: n[g]};
      if (grp.q)      mag = y4;
      else if (grp.t) mag = y3;
      else if (grp.d) mag = y2;
      else if (grp.s) mag = y1;
      else            mag = '0;
      if (grp.n) mag = -mag;
      P = P + (mag <<< (3 * g));
    end
  end
endmodule

// File: rtl/pe_os_r8_acc.sv
// Output-stationary radix-8 Booth PE: operand forwarding, 2-stage MAC,
// tile FSM, optional saturation and a daisy-chained shadow result.
module pe_os_r8_acc
  import pe_r8_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GC    = gc_of(WIDTH),
  parameter int GUARD = 4,
  parameter int ACC_W = 2 * WIDTH + GUARD,
  parameter int SAT   = 0
) (
  input  logic             CLK,
  input  logic             RST,
  pe_os_r8_acc_if.slave    opnd,
  pe_os_r8_acc_if.master   fwd,
  output logic [ACC_W-1:0] MAC_OUT,
  input  logic [ACC_W-1:0] RES_IN,
  input  logic             RES_IN_VLD,
  input  logic             RES_SHIFT,
  output logic [ACC_W-1:0] RES_OUT,
  output logic             RES_OUT_VLD,
  output logic [2:0]       ERR
);
  localparam int PW = 2 * WIDTH + 2;

  logic signed [PW-1:0] p0;
  logic signed [PW-1:0] p1;
  logic                 vld1;
  logic                 clr1;
  logic                 last1;

  tile_st_t             st;
  tile_st_t             st_n;
  logic                 acc_en;
  logic                 acc_clr;
  logic                 cap;
  logic                 seq_err;

  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_nxt;
  logic signed [63:0]   base64;
  logic signed [63:0]   p64;
  logic                 ovf;
  logic                 lost;

  r8_pp_sum #(
    .WIDTH (WIDTH),
    .GC    (GC)
  ) u_pp (
    .s   (opnd.s),
    .d   (opnd.d),
    .t   (opnd.t),
    .q   (opnd.q),
    .n   (opnd.n),
    .Y   (opnd.Y),
    .TMY (opnd.TMY),
    .P   (p0)
  );

  // forward every operand and control bit to the neighbours, ungated
  always_ff @(posedge CLK) begin
    if (RST) begin
      fwd.VLD  <= 1'b0;
      fwd.CLR  <= 1'b0;
      fwd.LAST <= 1'b0;
      fwd.s    <= '0;
      fwd.d    <= '0;
      fwd.t    <= '0;
      fwd.q    <= '0;
      fwd.n    <= '0;
      fwd.Y    <= '0;
      fwd.TMY  <= '0;
    end else begin
      fwd.VLD  <= opnd.VLD;
      fwd.CLR  <= opnd.CLR;
      fwd.LAST <= opnd.LAST;
      fwd.s    <= opnd.s;
      fwd.d    <= opnd.d;
      fwd.t    <= opnd.t;
      fwd.q    <= opnd.q;
      fwd.n    <= opnd.n;
      fwd.Y    <= opnd.Y;
      fwd.TMY  <= opnd.TMY;
    end
  end

  // stage 1: register the product with its beat controls
  always_ff @(posedge CLK) begin
    if (RST) begin
      p1    <= '0;
      vld1  <= 1'b0;
      clr1  <= 1'b0;
      last1 <= 1'b0;
    end else begin
      p1    <= p0;
      vld1  <= opnd.VLD;
      clr1  <= opnd.CLR;
      last1 <= opnd.LAST;
    end
  end

  // tile state register
  always_ff @(posedge CLK) begin
    if (RST) st <= IDLE;
    else     st <= st_n;
  end

  // tile next-state and beat actions from stage-1 controls
  always_comb begin
    st_n    = st;
    acc_en  = 1'b0;
    acc_clr = 1'b0;
    cap     = 1'b0;
    seq_err = 1'b0;
    if (vld1) begin
      unique case (st)
        IDLE: begin
          if (clr1) begin
            acc_en  = 1'b1;
            acc_clr = 1'b1;
            cap     = last1;
            st_n    = last1 ? IDLE : RUN;
          end else begin
            seq_err = 1'b1;
          end
        end
        RUN: begin
          acc_en  = 1'b1;
          acc_clr = clr1;
          seq_err = clr1;
          cap     = last1;
          if (last1) st_n = IDLE;
        end
        default: st_n = IDLE;
      endcase
    end
  end

  // next accumulator value, wrapped or clamped
  always_comb begin
    base64  = acc_clr ? 64'sd0
                      : {{(64-ACC_W){acc[ACC_W-1]}}, acc};
    p64     = {{(64-PW){p1[PW-1]}}, p1};
    ovf     = add_ovf(base64, p64, ACC_W);
    acc_nxt = ACC_W'(sat_add(base64, p64, ACC_W, SAT != 0));
  end

  // stage 2: accumulate on accepted beats
  always_ff @(posedge CLK) begin
    if (RST)         acc <= '0;
    else if (acc_en) acc <= acc_nxt;
  end

  assign MAC_OUT = acc;

  // a capture destroys either incoming chain data or an undrained result
  assign lost = cap & (RES_SHIFT ? RES_IN_VLD : RES_OUT_VLD);

  // shadow result: capture at tile end, otherwise shift down the column
  always_ff @(posedge CLK) begin
    if (RST) begin
      RES_OUT     <= '0;
      RES_OUT_VLD <= 1'b0;
    end else if (cap) begin
      RES_OUT     <= acc_nxt;
      RES_OUT_VLD <= 1'b1;
    end else if (RES_SHIFT) begin
      RES_OUT     <= RES_IN;
      RES_OUT_VLD <= RES_IN_VLD;
    end
  end

  // sticky error flags
  always_ff @(posedge CLK) begin
    if (RST) begin
      ERR <= '0;
    end else begin
      if (seq_err) ERR[ERR_SEQ] <= 1'b1;
      if (lost)    ERR[ERR_OVR] <= 1'b1;
      if (acc_en && ovf && (SAT != 0)) ERR[ERR_SAT] <= 1'b1;
    end
  end
endmodule

// File: doc/pe_os_r8_acc.md
Name: pe_os_r8_acc

Overview:
- Parametrised next-generation output-stationary systolic PE. Consumes radix-8 Booth digit groups: one-hot magnitude s/d/t/q (×1/×2/×3/×4), negate n, and precomputed 3Y (TMY).
- Forwards all operands to its neighbours with a 1-cycle register delay.
- Adds a 2-stage MAC pipeline, a tile-control FSM, an optional saturating accumulator, and a shadow result register that unloads over a daisy-chain while the next tile accumulates.
- Instantiated in an R×C grid. Y/TMY flow horizontally, digit groups flow vertically, and results drain along columns.

Parameters:
- WIDTH, 8, signed multiplicand/multiplier width.
- GC, (WIDTH+3)/3, Booth digit-group count, ceil((WIDTH+1)/3).
- GUARD, 4, accumulator guard bits.
- ACC_W, 2*WIDTH+GUARD, accumulator and result width.
- SAT, 0, 0 = two's-complement wrap, 1 = saturate to ACC_W signed limits.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- VLD  in  1  operand valid
- CLR  in  1  first beat of tile (qualified by VLD)
- LAST  in  1  final beat of tile (qualified by VLD)
- s, d, t, q, n  in  GC each  Booth group g: magnitude one-hot, n = negate
- Y  in  WIDTH  signed multiplicand
- TMY  in  WIDTH+2  signed 3*Y
- VLD_OUT, CLR_OUT, LAST_OUT  out  1  registered pass-through
- S_OUT, D_OUT, T_OUT, Q_OUT, N_OUT  out  GC  registered pass-through
- Y_OUT  out  WIDTH  registered pass-through
- TMY_OUT  out  WIDTH+2  registered pass-through
- MAC_OUT  out  ACC_W  live accumulator
- RES_IN  in  ACC_W  result from upstream PE
- RES_IN_VLD  in  1  upstream shadow valid
- RES_SHIFT  in  1  column-wide drain strobe
- RES_OUT  out  ACC_W  shadow register
- RES_OUT_VLD  out  1  shadow valid
- ERR  out  3  sticky flags: [0] sequence, [1] shadow overrun, [2] saturation

Behaviour:
- Reset: all outputs, pipeline registers, accumulator, shadow and flags = 0. FSM = IDLE. Reset mid-tile discards all in-flight data.
- Pass-through:
  - All *_OUT operand/control ports register inputs at every edge, unconditionally.
  - Latency 1. No gating by VLD.
- Stage 1 (edge E0):
  - P = sum over g of sel_g << 3g.
  - sel_g = Y, 2Y, TMY or 4Y for s, d, t or q respectively, negated if n.
  - Magnitude priority q>t>d>s if more than one bit is set.
  - No magnitude bit set gives 0, with n ignored.
  - P is signed, 2*WIDTH+2 bits. It is registered together with vld1/clr1/last1.
- Stage 2 (edge E1):
  - If vld1: acc <= (clr1 ? 0 : acc) + sext(P).
  - SAT=1: on overflow, clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1) and set ERR[2]. SAT=0 wraps silently.
  - MAC_OUT = acc. Input-to-MAC_OUT latency is 2 edges.
- Tile FSM, evaluated on stage-1 control:
  - IDLE -> RUN on vld1&clr1.
  - RUN -> IDLE on vld1&last1.
  - vld1&clr1&last1 is a one-beat tile: stay or return to IDLE, and capture the result.
  - vld1 without clr1 in IDLE: beat dropped (acc unchanged), ERR[0] set.
  - clr1 in RUN: restart (acc reloaded with P), ERR[0] set.
- Shadow register:
  - On the stage-2 edge with vld1&last1 in a legal state: shadow <= new acc value, RES_OUT_VLD <= 1.
  - Else if RES_SHIFT: shadow <= RES_IN, RES_OUT_VLD <= RES_IN_VLD.
  - Capture and shift in the same cycle: capture wins. Set ERR[1] if RES_IN_VLD=1, because upstream data is lost.
  - Capture while RES_OUT_VLD=1 and no shift: overwrite, set ERR[1].
- ERR bits clear only on RST.

Decomposition:
- Shared package pe_r8_pkg:
  - GC function ceil((WIDTH+1)/3).
  - Booth group struct {s, d, t, q, n}.
  - FSM enum {IDLE, RUN}.
  - ERR bit index constants.
  - Saturating-add function.
- One natural sub-module: r8_pp_sum, the combinational selection and shift-add of GC partial products. It is reusable by the weight-stationary variant.

Test Plan (WIDTH=8, GUARD=4 unless stated):
- Y=5, TMY=15, t[0]=1, VLD/CLR/LAST=1 for one beat -> MAC_OUT=15 after 2 edges; RES_OUT=15, RES_OUT_VLD=1; all *_OUT echo inputs after 1 edge.
- Y=3, TMY=9, digits q[0], q[1], s[2] (=100), CLR beat then a repeat beat with LAST -> MAC_OUT 300 then 600; shadow=600.
- Y=-7, TMY=-21, digits s[0]n[0], d[2] (=127), one-beat tile -> MAC_OUT=-889 (ACC_W two's complement).
- SAT=1, GUARD=2 (ACC_W=18), Y=127, TMY=381, multiplier 127, 9 beats -> after beat 8 acc=129032; after beat 9 acc=131071 and ERR[2]=1. With SAT=0, beat 9 wraps to -117,0… (145161-262144=-116983).
- Two-PE chain: PE0 captures 15, PE1 captures 300, then RES_SHIFT pulses -> PE1.RES_OUT=15 with VLD=1; second pulse -> 0 with VLD=0, no ERR.
- VLD beat without CLR after reset -> MAC_OUT stays 0, ERR[0]=1. Second LAST before drain -> ERR[1]=1 and shadow overwritten. RST asserted mid-tile -> all outputs 0 next edge.
